// File: rtl/key_pio_pkg.sv
// Shared register map and elaboration helpers for the key input PIO.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CFG = 2'd3;

    // Bits needed to count 0..value-1; callers guarantee value >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        int unsigned rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One input line: synchronizer chain, stability counter, debounced level and
// a single-cycle change strobe coincident with the edge that updates stable.
module key_debounce
    import key_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic stable,
    output logic chg
);

    localparam int unsigned CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          count;
    logic                   differs;

    assign differs = sync_q[SYNC_STAGES-1] != stable;
    assign chg     = differs && (count == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            stable <= RESET_VALUE;
        end else if (!differs) begin
            count <= '0;
        end else if (chg) begin
            count  <= '0;
            stable <= sync_q[SYNC_STAGES-1];
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/key_input_pio.sv
// Avalon-MM push-button/switch input port: debounced DATA, MASK, W1C CAPTURE
// and per-bit EDGE_CFG registers with a registered level interrupt.
module key_input_pio
    import key_pio_pkg::*;
#(
    parameter int unsigned     WIDTH           = 8,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_chipselect,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] key_in
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cfg;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_word;
    logic             wr_en;
    logic             rd_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        key_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .key_in (key_in[i]),
            .stable (stable[i]),
            .chg    (chg[i])
        );
    end

    assign wr_en = avs_chipselect && avs_write;
    assign rd_en = avs_chipselect && avs_read;

    // chg means stable is about to flip, so the incoming level is ~stable.
    assign edge_hit = chg & (~stable ^ edge_cfg);
    assign w1c      = (wr_en && avs_address == ADDR_CAPTURE) ? avs_writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA:     rd_word[WIDTH-1:0] = stable;
            ADDR_MASK:     rd_word[WIDTH-1:0] = mask;
            ADDR_CAPTURE:  rd_word[WIDTH-1:0] = capture;
            ADDR_EDGE_CFG: rd_word[WIDTH-1:0] = edge_cfg;
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            edge_cfg <= '0;
        end else if (wr_en) begin
            if (avs_address == ADDR_MASK)     mask     <= avs_writedata[WIDTH-1:0];
            if (avs_address == ADDR_EDGE_CFG) edge_cfg <= avs_writedata[WIDTH-1:0];
        end
    end

    // A new edge outranks a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~w1c) | edge_hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (rd_en) avs_readdata <= rd_word;
            irq <= |(capture & mask);
        end
    end

endmodule

// File: tb/tb_key_input_pio.sv
// Directed self-checking bench for key_input_pio with a 4-cycle debounce.
module tb_key_input_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  key_in;

    int errors;
    int checks;

    key_input_pio #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .RESET_VALUE    (8'h00)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_chipselect(avs_chipselect),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .key_in        (key_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = 2'd0;
        avs_writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = addr;
        avs_writedata  = data;
        tick(1);
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = addr;
        tick(1);
        bus_idle();
        data = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus_idle();
        key_in  = 8'h00;
        reset_n = 1'b0;
        tick(3);
        checks++;
        if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b, required 00000000 / 0", avs_readdata, irq);
        end
        reset_n = 1'b1;
        tick(2);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h, required 00000000", a, rd);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b, required 0", irq);
        end
        // Reset partway through a debounce count.
        key_in = 8'hFF;
        tick(4);
        reset_n = 1'b0;
        key_in  = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_midcount_data: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] rd;
        key_in         = 8'h01;
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = 2'd0;
        // stable flips on the 6th edge; readdata shows it one edge later.
        tick(6);
        checks++;
        if (avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL debounce_early: got %h, required 00000000", avs_readdata);
        end
        tick(1);
        checks++;
        if (avs_readdata !== 32'h1) begin
            errors++;
            $display("FAIL debounce_latency: got %h, required 00000001", avs_readdata);
        end
        bus_idle();
        tick(2);
        checks++;
        if (avs_readdata !== 32'h1) begin
            errors++;
            $display("FAIL readdata_hold: got %h, required 00000001", avs_readdata);
        end
        bus_write(2'd2, 32'hFF);
        tick(1);
        key_in = 8'h03;
        tick(3);
        key_in = 8'h01;
        tick(10);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL glitch_data: got %h, required 00000001", rd);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL glitch_capture: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd;
        bus_write(2'd1, 32'h01);
        bus_write(2'd3, 32'h00);
        key_in = 8'h00;
        tick(10);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rising_ignores_fall: capture=%h irq=%b, required 00000000 / 0", rd, irq);
        end
        key_in = 8'h01;
        tick(6);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b, required 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_assert: got %b, required 1", irq);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL rising_capture: got %h, required 00000001", rd);
        end
        bus_write(2'd2, 32'h01);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_clear_lag: got %b, required 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_deassert: got %b, required 0", irq);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL capture_w1c: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_falling_edge();
        logic [31:0] rd;
        bus_write(2'd3, 32'h80);
        bus_write(2'd1, 32'h80);
        key_in = 8'h81;
        tick(10);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL falling_ignores_rise: capture=%h irq=%b, required 00000000 / 0", rd, irq);
        end
        key_in = 8'h01;
        tick(10);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h80 || irq !== 1'b1) begin
            errors++;
            $display("FAIL falling_capture: capture=%h irq=%b, required 00000080 / 1", rd, irq);
        end
        bus_write(2'd2, 32'h80);
        tick(2);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL falling_clear_irq: got %b, required 0", irq);
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        key_in = 8'h00;
        tick(10);
        key_in = 8'h01;
        // chg for bit 0 is high between the 5th and 6th edges.
        tick(5);
        bus_write(2'd2, 32'h01);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL collision_set_wins: got %h, required 00000001", rd);
        end
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_address    = 2'd1;
        avs_writedata  = 32'h5A;
        tick(1);
        bus_idle();
        checks++;
        if (avs_readdata !== 32'h80) begin
            errors++;
            $display("FAIL rw_old_value: got %h, required 00000080", avs_readdata);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h5A) begin
            errors++;
            $display("FAIL rw_new_mask: got %h, required 0000005a", rd);
        end
    endtask

    task automatic test_mask_gating();
        logic [31:0] rd;
        bus_write(2'd2, 32'hFF);
        bus_write(2'd1, 32'h00);
        bus_write(2'd3, 32'h00);
        key_in = 8'h05;
        tick(10);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_capture: capture=%h irq=%b, required 00000004 / 0", rd, irq);
        end
        bus_write(2'd1, 32'h04);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_irq_lag: got %b, required 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_irq_assert: got %b, required 1", irq);
        end
        bus_write(2'd0, 32'h00);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL data_readonly: got %h, required 00000005", rd);
        end
        bus_write(2'd3, 32'hFFFF_FFFF);
        tick(2);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL edgecfg_no_capture: got %h, required 00000004", rd);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL edgecfg_high_bits: got %h, required 000000ff", rd);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_debounce();
        test_edge_irq();
        test_falling_edge();
        test_collision();
        test_mask_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_input_pio.md
Name: key_input_pio

Overview:
- Avalon-MM slave input port: the inbound counterpart of the 8-bit LED output port on the HPS lightweight bridge.
- Samples external push-buttons and switches, synchronizes and debounces them, and captures edges.
- Raises a level interrupt to the HPS. The HPS reads the debounced state and clears captured edges over the bridge.

Parameters:
- WIDTH, 8, number of input lines (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a line change is accepted (>=2); 1 ms at 50 MHz.
- SYNC_STAGES, 2, synchronizer flip-flop depth (>=2).
- RESET_VALUE, 0, WIDTH-bit reset value of the debounced state.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  word register index.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid the cycle after the read.
- irq  out  1  level interrupt to the HPS.
- key_in  in  WIDTH  raw asynchronous inputs.

Behaviour:
- Reset (asynchronous, reset_n=0): all of the following return to their reset values.
  - synchronizer flops = RESET_VALUE, stable = RESET_VALUE
  - counters = 0, mask = 0, edge_cfg = 0, capture = 0
  - avs_readdata = 0, irq = 0
- Reset mid-debounce discards the partial count.
- Synchronizer: SYNC_STAGES-deep chain per bit. sync[i] is the last stage.
- Debounce, per bit, with counter width = clog2(DEBOUNCE_CYCLES):
  - sync == stable: count <= 0.
  - sync != stable and count < DEBOUNCE_CYCLES-1: count <= count+1.
  - sync != stable and count == DEBOUNCE_CYCLES-1: stable <= sync, count <= 0, one-cycle chg pulse.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency from key_in change to stable change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge select, per bit: edge_cfg[i]=0 means rising (stable 0->1); edge_cfg[i]=1 means falling (1->0).
- A selected chg sets capture[i].
- Register map, word addresses; unused high bits read 0, writes to them are ignored:
  - 0 DATA: read-only, = stable. Writes ignored.
  - 1 MASK: read/write, bits [WIDTH-1:0].
  - 2 CAPTURE: read returns capture. Writing 1 clears that bit; writing 0 has no effect.
  - 3 EDGE_CFG: read/write, bits [WIDTH-1:0].
- A transaction occurs only when avs_chipselect=1.
- Read latency is fixed at 1. avs_readdata holds its value when no read is in progress. There is no waitrequest.
- Simultaneous events:
  - An edge and a W1C of the same capture bit in the same cycle: set wins, the bit stays 1.
  - avs_read and avs_write asserted together: write takes effect, readdata returns the pre-write value.
- An EDGE_CFG change does not generate a capture by itself.
- irq is registered: irq <= |(capture & mask). It asserts 1 cycle after the capture or mask update and deasserts 1 cycle after the clear.
- If the input differs from RESET_VALUE out of reset, stable updates after the normal latency and may capture an edge.

Decomposition:
- Package key_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_CAPTURE=2, ADDR_EDGE_CFG=3
  - function clog2
- One sub-module, key_debounce: a single bit with synchronizer, counter, stable output and chg pulse, parameterized by SYNC_STAGES and DEBOUNCE_CYCLES. Instantiate it WIDTH times in a generate loop.
- The top level holds the registers, edge logic, bus decode and irq.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: release reset_n with key_in=0x00, then read addresses 0..3 -> all 0x00000000, irq=0; assert reset_n mid-count -> stable stays 0x00.
- Debounce: key_in=0x01 held -> DATA reads 0x01 exactly 6 cycles after the change; a 3-cycle pulse 0x02 -> DATA stays 0x01, CAPTURE stays 0x00.
- Edge and irq: MASK=0x01, EDGE_CFG=0x00, key_in 0->1 on bit 0 -> CAPTURE=0x01, irq=1 one cycle later; writing CAPTURE=0x01 -> CAPTURE=0x00, irq=0 one cycle after.
- Falling edge select: EDGE_CFG=0x80, MASK=0x80; bit 7 goes 0->1 -> no capture; bit 7 goes 1->0 -> CAPTURE=0x80, irq=1.
- Collision: W1C of bit 0 in the same cycle as its chg pulse -> CAPTURE bit 0 remains 1; read and write of MASK together -> readdata shows the old MASK value.
- Mask gating: CAPTURE=0x04 with MASK=0x00 -> irq=0; write MASK=0x04 -> irq=1 one cycle later; write to DATA -> DATA unchanged.
